pkt_merger: RTL

- Merges packets from NUM_CHANNELS independent valid/ready input channels into one output stream.
- Uses fair round-robin arbitration and a registered output stage.
- Sits at the far end of the packet router's per-channel outputs. It re-aggregates routed traffic onto a single link, e.g. the loop-back or monitoring path.
- Reports the source channel of each output packet and keeps a running count of delivered packets.

---
 rtl/pkt_merger_if.sv | 33 +++
 rtl/pkt_merger.sv | 108 ++++++++++
 2 files changed

// File: rtl/pkt_merger_if.sv
`timescale 1ns/1ps
// Bus bundle for pkt_merger: per-channel valid/ready packet inputs, one merged
// valid/ready output with its source channel, and the delivered-packet count.
//   master : upstream channels + downstream sink (drives inputs, reads outputs)
//   slave  : the merger itself
interface pkt_merger_if #(
  parameter int unsigned PACKET_BITS  = 72,
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned CHAN_BITS    = 3
);
  localparam int unsigned CNT_BITS = 32;

  logic [PACKET_BITS-1:0]  pkt_in_data_in [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] pkt_in_vld_in;
  logic [NUM_CHANNELS-1:0] pkt_in_rdy_out;
  logic [PACKET_BITS-1:0]  pkt_out_data_out;
  logic                    pkt_out_vld_out;
  logic                    pkt_out_rdy_in;
  logic [CHAN_BITS-1:0]    pkt_out_chan_out;
  logic [CNT_BITS-1:0]     merge_cnt_out;

  modport master (
    output pkt_in_data_in, pkt_in_vld_in, pkt_out_rdy_in,
    input  pkt_in_rdy_out, pkt_out_data_out, pkt_out_vld_out,
    input  pkt_out_chan_out, merge_cnt_out
  );

  modport slave (
    input  pkt_in_data_in, pkt_in_vld_in, pkt_out_rdy_in,
    output pkt_in_rdy_out, pkt_out_data_out, pkt_out_vld_out,
    output pkt_out_chan_out, merge_cnt_out
  );
endinterface

// File: rtl/pkt_merger.sv
`timescale 1ns/1ps
// pkt_merger: round-robin merge of NUM_CHANNELS valid/ready packet streams onto
// one registered output stream (1 packet/cycle), tagging each packet with its
// source channel and counting packets delivered downstream.
// Ports:
//   clk_tb    clock
//   reset_tb  asynchronous active-high reset
//   bus       pkt_merger_if.slave: pkt_in_data_in/vld_in/rdy_out per channel,
//             pkt_out_data_out/vld_out/rdy_in/chan_out, merge_cnt_out
module pkt_merger #(
  parameter int unsigned PACKET_BITS  = 72,
  parameter int unsigned NUM_CHANNELS = 8,
  parameter int unsigned CHAN_BITS    = 3
) (
  input  logic         clk_tb,
  input  logic         reset_tb,
  pkt_merger_if.slave  bus
);

  localparam int unsigned CNT_BITS = 32;
  localparam logic [CHAN_BITS-1:0] LAST_CHAN = CHAN_BITS'(NUM_CHANNELS - 1);

  logic [PACKET_BITS-1:0]  out_data_q, out_data_d;
  logic                    out_vld_q,  out_vld_d;
  logic [CHAN_BITS-1:0]    out_chan_q, out_chan_d;
  logic [CHAN_BITS-1:0]    ptr_q,      ptr_d;
  logic [CNT_BITS-1:0]     cnt_q,      cnt_d;

  logic                    load_en_c;
  logic                    drain_c;
  logic                    accept_c;
  logic                    win_found_c;
  logic [CHAN_BITS-1:0]    win_idx_c;
  logic [CHAN_BITS-1:0]    cand_c;
  logic [NUM_CHANNELS-1:0] rdy_c;

  // Output register can take a packet when empty or draining this cycle.
  assign load_en_c = !out_vld_q || bus.pkt_out_rdy_in;
  assign drain_c   = out_vld_q && bus.pkt_out_rdy_in;
  // Ready is held low throughout reset even if upstream keeps valid asserted.
  assign accept_c  = win_found_c && load_en_c && !reset_tb;

  // Round-robin scan: first valid channel at or after the pointer wins.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      cand_c = CHAN_BITS'((32'(ptr_q) + i) % NUM_CHANNELS);
      if (!win_found_c && bus.pkt_in_vld_in[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

  // Only the winner sees ready; it follows load_en so a stall blocks everyone.
  always_comb begin
    rdy_c = '0;
    if (accept_c) begin
      rdy_c[win_idx_c] = 1'b1;
    end
  end

  // Next-state for output register, pointer and delivered count.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    if (drain_c) begin
      cnt_d = cnt_q + CNT_BITS'(1);
    end
    if (accept_c) begin
      out_vld_d  = 1'b1;
      out_data_d = bus.pkt_in_data_in[win_idx_c];
      out_chan_d = win_idx_c;
      ptr_d      = (win_idx_c == LAST_CHAN) ? '0 : win_idx_c + CHAN_BITS'(1);
    end else if (drain_c) begin
      // Data and channel keep their last values once the register empties.
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_tb or posedge reset_tb) begin
    if (reset_tb) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_chan_q <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.pkt_in_rdy_out   = rdy_c;
  assign bus.pkt_out_data_out = out_data_q;
  assign bus.pkt_out_vld_out  = out_vld_q;
  assign bus.pkt_out_chan_out = out_chan_q;
  assign bus.merge_cnt_out    = cnt_q;

endmodule
